// File: rtl/linear_encoder_pkg.sv
// Shared types for the linear-encoder DMA: FSM states, descriptor payload and widths.
package linear_encoder_pkg;

  localparam int LINEAR_ENCODER_STATE_W = 2;
  localparam int LINEAR_ENCODER_ADDR_W  = 64;
  localparam int LINEAR_ENCODER_LEN_W   = 16;

  typedef enum logic [LINEAR_ENCODER_STATE_W-1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } linear_encoder_state_e;

  typedef struct packed {
    logic [LINEAR_ENCODER_ADDR_W-1:0] addr;
    logic [LINEAR_ENCODER_LEN_W-1:0]  len;
  } linear_encoder_desc_t;

endpackage

// File: rtl/linear_encoder_desc_gen.sv
// Burst descriptor generator for one DMA direction: burst index, address
// accumulator and a registered valid/ready handshake.
module linear_encoder_desc_gen #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              run,
  input  logic              ready,
  input  logic [LEN_W:0]    limit,
  input  logic [LEN_W-1:0]  n_bursts,
  input  logic [LEN_W-1:0]  full_len,
  input  logic [LEN_W-1:0]  last_len,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  len,
  output logic [LEN_W-1:0]  issued
);

  logic              fire;
  logic [LEN_W-1:0]  idx_next;
  logic [ADDR_W-1:0] addr_next;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fire      = valid && ready;
    idx_next  = issued;
    addr_next = addr;
    if (clear) begin
      idx_next  = '0;
      addr_next = base;
    end else if (fire) begin
      idx_next  = issued + LEN_W'(1);
      addr_next = addr + stride;
    end
  end

  // The next burst is presented as soon as its index is below the caller's
  // limit, so back-to-back descriptors follow a handshake without a gap.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      addr   <= '0;
      len    <= '0;
      issued <= '0;
    end else begin
      issued <= idx_next;
      addr   <= addr_next;
      valid  <= run && ({1'b0, idx_next} < limit);
      len    <= (idx_next == n_bursts - LEN_W'(1)) ? last_len : full_len;
    end
  end

endmodule

// File: rtl/linear_encoder_dma_ctrl.sv
// Linear-encoder DMA sequencing controller: bursts a message through read and
// write DMA engines. Optional EXEC cycle counter enabled by LINEAR_ENCODER_PERF_EN.
module linear_encoder_dma_ctrl
  import linear_encoder_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int LEN_W      = 16,
  parameter int BURST_LEN  = 256,
  parameter int ELEM_BYTES = 32,
  parameter int RATE       = 2,
  parameter int MAX_OUT    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_i,
  input  logic [ADDR_W-1:0]                 src_addr_i,
  input  logic [ADDR_W-1:0]                 dst_addr_i,
  input  logic [LEN_W-1:0]                  num_elems_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [LINEAR_ENCODER_STATE_W-1:0] state_o,
  output logic                              rd_req_valid_o,
  input  logic                              rd_req_ready_i,
  output logic [ADDR_W-1:0]                 rd_req_addr_o,
  output logic [LEN_W-1:0]                  rd_req_len_o,
  input  logic                              rd_done_i,
  output logic                              wr_req_valid_o,
  input  logic                              wr_req_ready_i,
  output logic [ADDR_W-1:0]                 wr_req_addr_o,
  output logic [LEN_W-1:0]                  wr_req_len_o,
  input  logic                              wr_done_i,
  output logic [31:0]                       cycles_o
);

  localparam int BURST_SH = $clog2(BURST_LEN);
  localparam int ELEM_SH  = $clog2(ELEM_BYTES);
  localparam logic [ADDR_W-1:0] RD_STRIDE   = ADDR_W'(1) << (BURST_SH + ELEM_SH);
  localparam logic [ADDR_W-1:0] WR_STRIDE   = ADDR_W'(RATE) << (BURST_SH + ELEM_SH);
  localparam logic [LEN_W-1:0]  RD_FULL_LEN = LEN_W'(BURST_LEN);
  localparam logic [LEN_W-1:0]  WR_FULL_LEN = LEN_W'(RATE * BURST_LEN);
  localparam logic [LEN_W-1:0]  RATE_L      = LEN_W'(RATE);
  localparam logic [LEN_W:0]    OUT_LIMIT   = (LEN_W+1)'(MAX_OUT);

  if (RATE * BURST_LEN >= 2 ** LEN_W) begin : g_rate_check
    $error("RATE*BURST_LEN does not fit in LEN_W");
  end

  linear_encoder_state_e state;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  num_q;
  logic [LEN_W-1:0]  n_bursts, last_len, wr_last_len;
  logic [LEN_W-1:0]  rd_issued, wr_issued, rd_cmp, wr_cmp;
  logic [LEN_W-1:0]  rd_cmp_next, wr_cmp_next;
  logic [LEN_W:0]    rd_window, rd_limit, wr_limit;
  logic              rd_accept, wr_accept, gen_clear, gen_run;

  // The job registers are frozen for the whole job, so the burst geometry can
  // be derived combinationally and is already valid during INIT.
  assign n_bursts    = (num_q >> BURST_SH) + LEN_W'(|num_q[BURST_SH-1:0]);
  assign last_len    = num_q - ((n_bursts - LEN_W'(1)) << BURST_SH);
  assign wr_last_len = last_len * RATE_L;
  assign gen_clear   = (state == INIT);
  assign gen_run     = (state == INIT) || (state == EXEC);
  assign state_o     = state;

  always_comb begin
    rd_accept   = (state == EXEC) && rd_done_i && (rd_issued != rd_cmp);
    wr_accept   = (state == EXEC) && wr_done_i && (wr_issued != wr_cmp);
    rd_cmp_next = (state == INIT) ? '0 : rd_cmp + LEN_W'(rd_accept);
    wr_cmp_next = (state == INIT) ? '0 : wr_cmp + LEN_W'(wr_accept);
    rd_window   = {1'b0, rd_cmp_next} + OUT_LIMIT;
    rd_limit    = (rd_window < {1'b0, n_bursts}) ? rd_window : {1'b0, n_bursts};
    wr_limit    = {1'b0, rd_cmp_next};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cmp <= '0;
      wr_cmp <= '0;
    end else begin
      rd_cmp <= rd_cmp_next;
      wr_cmp <= wr_cmp_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
      num_q  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          src_q  <= src_addr_i;
          dst_q  <= dst_addr_i;
          num_q  <= num_elems_i;
          state  <= INIT;
          busy_o <= 1'b1;
        end
        INIT: if (n_bursts == '0) begin
          state  <= DONE;
          done_o <= 1'b1;
        end else begin
          state  <= EXEC;
        end
        EXEC: if (wr_cmp_next == n_bursts) begin
          state  <= DONE;
          done_o <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  linear_encoder_desc_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (gen_clear),
    .run      (gen_run),
    .ready    (rd_req_ready_i),
    .limit    (rd_limit),
    .n_bursts (n_bursts),
    .full_len (RD_FULL_LEN),
    .last_len (last_len),
    .base     (src_q),
    .stride   (RD_STRIDE),
    .valid    (rd_req_valid_o),
    .addr     (rd_req_addr_o),
    .len      (rd_req_len_o),
    .issued   (rd_issued)
  );

  linear_encoder_desc_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (gen_clear),
    .run      (gen_run),
    .ready    (wr_req_ready_i),
    .limit    (wr_limit),
    .n_bursts (n_bursts),
    .full_len (WR_FULL_LEN),
    .last_len (wr_last_len),
    .base     (dst_q),
    .stride   (WR_STRIDE),
    .valid    (wr_req_valid_o),
    .addr     (wr_req_addr_o),
    .len      (wr_req_len_o),
    .issued   (wr_issued)
  );

`ifdef LINEAR_ENCODER_PERF_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
    end else if (state == INIT) begin
      cycles_q <= '0;
    end else if ((state == EXEC) && (cycles_q != '1)) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_linear_encoder_dma_ctrl.sv
// Randomized bench for linear_encoder_dma_ctrl: acts as both DMA engines and
// checks descriptors, throttling and job timing against a burst-list model.
module tb_linear_encoder_dma_ctrl;
  import linear_encoder_pkg::*;

  localparam int BURST   = 256;
  localparam int EB      = 32;
  localparam int RATE    = 2;
  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i;
  logic [63:0] src_addr_i, dst_addr_i;
  logic [15:0] num_elems_i;
  logic        busy_o, done_o;
  logic [1:0]  state_o;
  logic        rd_req_valid_o, rd_req_ready_i, rd_done_i;
  logic [63:0] rd_req_addr_o;
  logic [15:0] rd_req_len_o;
  logic        wr_req_valid_o, wr_req_ready_i, wr_done_i;
  logic [63:0] wr_req_addr_o;
  logic [15:0] wr_req_len_o;
  logic [31:0] cycles_o;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;
  linear_encoder_desc_t rd_exp[$];
  linear_encoder_desc_t wr_exp[$];

  always #5 clk = ~clk;

  linear_encoder_dma_ctrl #(
    .ADDR_W(64), .LEN_W(16), .BURST_LEN(BURST), .ELEM_BYTES(EB), .RATE(RATE), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .src_addr_i     (src_addr_i),
    .dst_addr_i     (dst_addr_i),
    .num_elems_i    (num_elems_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .state_o        (state_o),
    .rd_req_valid_o (rd_req_valid_o),
    .rd_req_ready_i (rd_req_ready_i),
    .rd_req_addr_o  (rd_req_addr_o),
    .rd_req_len_o   (rd_req_len_o),
    .rd_done_i      (rd_done_i),
    .wr_req_valid_o (wr_req_valid_o),
    .wr_req_ready_i (wr_req_ready_i),
    .wr_req_addr_o  (wr_req_addr_o),
    .wr_req_len_o   (wr_req_len_o),
    .wr_done_i      (wr_done_i),
    .cycles_o       (cycles_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    start_i        = 1'b0;
    src_addr_i     = '0;
    dst_addr_i     = '0;
    num_elems_i    = '0;
    rd_req_ready_i = 1'b0;
    wr_req_ready_i = 1'b0;
    rd_done_i      = 1'b0;
    wr_done_i      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_state"}, state_o, IDLE);
    check({tag, "_rd_valid"}, rd_req_valid_o, 0);
    check({tag, "_wr_valid"}, wr_req_valid_o, 0);
    check({tag, "_rd_addr"}, rd_req_addr_o, 0);
    check({tag, "_rd_len"}, rd_req_len_o, 0);
    check({tag, "_wr_addr"}, wr_req_addr_o, 0);
    check({tag, "_wr_len"}, wr_req_len_o, 0);
    check({tag, "_cycles"}, cycles_o, 0);
  endtask

  // Plays one job as both DMA engines. rrdy/wrdy/dn are percent probabilities
  // for ready and completion; hold withholds read completions for that many
  // EXEC cycles; rblock holds read ready low for the first EXEC cycles.
  task automatic run_job(input logic [63:0] src, input logic [63:0] dst, input int num,
                         input int rrdy, input int wrdy, input int dn,
                         input int hold, input int rblock);
    int n, t, fin, ex, rd_hs, wr_hs, rd_dn, wr_dn;
    bit rd_cnt, wr_cnt, r_stall, w_stall, finished;
    logic [63:0] p_raddr, p_waddr;
    logic [15:0] p_rlen, p_wlen;
    linear_encoder_desc_t e;

    n = (num + BURST - 1) / BURST;
    rd_exp.delete();
    wr_exp.delete();
    for (int k = 0; k < n; k++) begin
      int l;
      l = (k == n - 1) ? num - k * BURST : BURST;
      rd_exp.push_back('{addr: src + 64'(k) * 64'(BURST * EB), len: 16'(l)});
      wr_exp.push_back('{addr: dst + 64'(k) * 64'(BURST * RATE * EB), len: 16'(RATE * l)});
    end

    tick();
    idle_inputs();
    start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; num_elems_i = 16'(num);
    t = cyc;
    @(negedge clk);
    tick();
    start_i = 1'b0;
    src_addr_i = {$urandom, $urandom}; dst_addr_i = {$urandom, $urandom};
    num_elems_i = 16'($urandom);
    @(negedge clk);
    check("init_state", state_o, INIT);
    check("init_busy", busy_o, 1);

    fin = (n == 0) ? t + 1 : -1;
    rd_hs = 0; wr_hs = 0; rd_dn = 0; wr_dn = 0;
    r_stall = 0; w_stall = 0; finished = 0;
    p_raddr = '0; p_waddr = '0; p_rlen = '0; p_wlen = '0;

    for (int i = 0; i < 5000 && !finished; i++) begin
      tick();
      ex = cyc - t - 2;
      rd_req_ready_i = (ex < rblock) ? 1'b0 : ($urandom_range(99) < rrdy);
      wr_req_ready_i = $urandom_range(99) < wrdy;
      rd_cnt = (rd_hs != rd_dn) && (ex >= hold) && ($urandom_range(99) < dn);
      wr_cnt = (wr_hs != wr_dn) && ($urandom_range(99) < dn);
      // completions with nothing outstanding must be ignored
      rd_done_i = rd_cnt || ((rd_hs == rd_dn) && ($urandom_range(7) == 0));
      wr_done_i = wr_cnt || ((wr_hs == wr_dn) && ($urandom_range(7) == 0));
      start_i = (n > 0 && wr_dn < n) ? ($urandom_range(5) == 0) : 1'b0;
      src_addr_i = {$urandom, $urandom}; dst_addr_i = {$urandom, $urandom};
      num_elems_i = 16'($urandom);

      @(negedge clk);
      if (ex == 0 && n > 0) begin
        check("exec_state", state_o, EXEC);
        check("first_rd_valid", rd_req_valid_o, 1);
      end
      if (n == 0) check("zero_no_valid", rd_req_valid_o | wr_req_valid_o, 0);
      if (r_stall) begin
        check("rd_hold_valid", rd_req_valid_o, 1);
        check("rd_hold_addr", rd_req_addr_o, p_raddr);
        check("rd_hold_len", rd_req_len_o, p_rlen);
      end
      if (w_stall) begin
        check("wr_hold_valid", wr_req_valid_o, 1);
        check("wr_hold_addr", wr_req_addr_o, p_waddr);
        check("wr_hold_len", wr_req_len_o, p_wlen);
      end
      if (rd_req_valid_o && rd_req_ready_i) begin
        check("rd_window", (rd_hs - rd_dn) < MAX_OUT, 1);
        if (rd_exp.size() == 0) check("rd_extra", 1, 0);
        else begin
          e = rd_exp.pop_front();
          check("rd_addr", rd_req_addr_o, e.addr);
          check("rd_len", rd_req_len_o, e.len);
        end
        rd_hs++;
      end
      if (wr_req_valid_o && wr_req_ready_i) begin
        check("wr_order", wr_hs < rd_dn, 1);
        if (wr_exp.size() == 0) check("wr_extra", 1, 0);
        else begin
          e = wr_exp.pop_front();
          check("wr_addr", wr_req_addr_o, e.addr);
          check("wr_len", wr_req_len_o, e.len);
        end
        wr_hs++;
      end
      r_stall = rd_req_valid_o && !rd_req_ready_i;
      w_stall = wr_req_valid_o && !wr_req_ready_i;
      p_raddr = rd_req_addr_o; p_rlen = rd_req_len_o;
      p_waddr = wr_req_addr_o; p_wlen = wr_req_len_o;
      rd_dn += int'(rd_cnt);
      wr_dn += int'(wr_cnt);
      if (wr_cnt && wr_dn == n) fin = cyc;
      if (hold > 0 && ex == hold)
        check("throttle_reads", rd_hs, (n < MAX_OUT) ? n : MAX_OUT);
      if (fin >= 0 && cyc == fin + 1) begin
        check("done_pulse", done_o, 1);
        check("done_state", state_o, DONE);
        finished = 1;
      end else if (done_o) begin
        check("done_early", done_o, 0);
      end
    end
    if (!finished) check("job_timeout", 0, 1);

    tick();
    idle_inputs();
    @(negedge clk);
    check("end_state", state_o, IDLE);
    check("end_busy", busy_o, 0);
    check("end_done", done_o, 0);
    check("end_valids", rd_req_valid_o | wr_req_valid_o, 0);
    check("rd_total", rd_hs, n);
    check("wr_total", wr_hs, n);
`ifdef LINEAR_ENCODER_PERF_EN
    check("exec_cycles", cycles_o, (n == 0) ? 0 : fin - t - 1);
`else
    check("exec_cycles", cycles_o, 0);
`endif
  endtask

  task automatic reset_mid_exec();
    int rd_hs;
    rd_hs = 0;
    tick();
    idle_inputs();
    start_i = 1'b1; src_addr_i = 64'h0; dst_addr_i = 64'h4_0000; num_elems_i = 16'd2560;
    @(negedge clk);
    tick();
    start_i = 1'b0;
    rd_req_ready_i = 1'b1;
    wr_req_ready_i = 1'b1;
    for (int i = 0; i < 40 && rd_hs < 3; i++) begin
      tick();
      @(negedge clk);
      if (rd_req_valid_o && rd_req_ready_i) rd_hs++;
    end
    check("reset_reads_seen", rd_hs, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_valid", rd_req_valid_o, 0);
    check("rst_wr_valid", wr_req_valid_o, 0);
    check("rst_state", state_o, IDLE);
    check("rst_busy", busy_o, 0);
    idle_inputs();
    #10;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_job(64'h1000, 64'h8000, 100, 100, 100, 100, 0, 0);
    run_job(64'h0, 64'h10_0000, 2560, 100, 100, 100, 30, 0);
    run_job(64'h5000, 64'h6000, 0, 100, 100, 100, 0, 0);
    run_job(64'h2_0000, 64'h3_0000, 700, 60, 60, 50, 0, 5);
    reset_mid_exec();
    run_job(64'h2000, 64'h9000, 300, 100, 100, 100, 0, 0);
    run_job(64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_C000, 900, 70, 70, 60, 0, 0);

    for (int j = 0; j < 8; j++) begin
      run_job({$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(3000)),
              int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
              int'($urandom_range(100, 30)), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
